// File: rtl/event_encoder_pkg.sv
// Shared definitions for the event encoder: FSM state encoding and default sizing.
// The helper below is used by the top to form the one-hot clear mask for a handshake.
package event_encoder_pkg;

  localparam int DEFAULT_N  = 8;
  localparam int DEFAULT_CW = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  // One-hot mask with bit idx set, sized to the widest supported vector (16 lines).
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    logic [15:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/event_encoder_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder: index of the lowest 1 in vec,
// plus a flag telling whether any bit is set at all.
module lsb_prio_enc
  import event_encoder_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Edge-detecting event encoder: rising edges on E_in become pending events that are
// presented one at a time, lowest index first, over a valid/ready handshake.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  E_in,
  input  logic          E_ready,
  input  logic          E_ovr_clr,
  output logic [CW-1:0] E_code,
  output logic          E_valid,
  output logic          E_overrun
);

  enc_state_t    state;
  enc_state_t    state_next;
  logic [N-1:0]  prev;
  logic [N-1:0]  pend;
  logic [N-1:0]  pend_next;
  logic [N-1:0]  rise;
  logic [N-1:0]  clr_mask;
  logic [15:0]   clr_wide;
  logic          handshake;
  logic          ovr_hit;
  logic          overrun_next;
  logic [CW-1:0] code_next;
  logic [CW-1:0] sel_idx;
  logic          sel_any;

  lsb_prio_enc #(
    .N  (N),
    .CW (CW)
  ) u_prio (
    .vec (pend),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign E_valid   = (state == PRESENT);
  assign handshake = E_valid & E_ready;
  assign rise      = E_in & ~prev;
  assign clr_wide  = onehot16(4'(E_code));

  // A fresh rise on the bit being cleared keeps it pending; this is not an overrun.
  always_comb begin
    clr_mask     = '0;
    if (handshake) begin
      clr_mask = clr_wide[N-1:0];
    end
    pend_next    = (pend & ~clr_mask) | rise;
    ovr_hit      = |(rise & pend & ~clr_mask);
    overrun_next = E_overrun;
    if (ovr_hit) begin
      overrun_next = 1'b1;
    end else if (E_ovr_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    code_next  = E_code;
    unique case (state)
      IDLE: begin
        if (sel_any) begin
          state_next = PRESENT;
          code_next  = sel_idx;
        end
      end
      PRESENT: begin
        if (handshake) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      E_code <= '0;
    end else begin
      state  <= state_next;
      E_code <= code_next;
    end
  end

  // prev loads all-ones on reset so lines already high do not look like new edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '1;
      pend      <= '0;
      E_overrun <= 1'b0;
    end else begin
      prev      <= E_in;
      pend      <= pend_next;
      E_overrun <= overrun_next;
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios then random traffic,
// all compared against an event-level reference model of pending lines.
module tb_event_encoder;

  localparam int N  = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  E_in;
  logic          E_ready;
  logic          E_ovr_clr;
  logic [CW-1:0] E_code;
  logic          E_valid;
  logic          E_overrun;

  int total_checks;
  int passed_checks;

  // Reference model state: which lines hold an unserved event, what is on offer.
  bit m_pend[N];
  bit m_prev[N];
  bit m_presenting;
  int m_code;
  bit m_overrun;

  event_encoder #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .E_in      (E_in),
    .E_ready   (E_ready),
    .E_ovr_clr (E_ovr_clr),
    .E_code    (E_code),
    .E_valid   (E_valid),
    .E_overrun (E_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of model behaviour, from the rules: edges become events, one event
  // per handshake is consumed, an unconsumed repeat event is lost.
  task automatic modelStep(input logic [N-1:0] in_v, input logic rdy, input logic oc, input logic rs);
    bit served;
    bit lost;
    int first;
    bit old_pend[N];
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b1;
      end
      m_presenting = 1'b0;
      m_code       = 0;
      m_overrun    = 1'b0;
      return;
    end
    served = m_presenting && rdy;
    lost   = 1'b0;
    old_pend = m_pend;
    for (int i = 0; i < N; i++) begin
      bit is_new;
      bit taken;
      is_new = in_v[i] && !m_prev[i];
      taken  = served && (m_code == i);
      if (is_new && m_pend[i] && !taken) lost = 1'b1;
      if (is_new) m_pend[i] = 1'b1;
      else if (taken) m_pend[i] = 1'b0;
      m_prev[i] = in_v[i];
    end
    if (!m_presenting) begin
      first = -1;
      for (int i = 0; i < N; i++) begin
        if (old_pend[i] && first < 0) first = i;
      end
      if (first >= 0) begin
        m_presenting = 1'b1;
        m_code       = first;
      end
    end else if (served) begin
      m_presenting = 1'b0;
    end
    if (lost) m_overrun = 1'b1;
    else if (oc) m_overrun = 1'b0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] in_v, input logic rdy, input logic oc, input logic rs);
    @(negedge clk);
    E_in      = in_v;
    E_ready   = rdy;
    E_ovr_clr = oc;
    rst       = rs;
    @(posedge clk);
    modelStep(in_v, rdy, oc, rs);
    #1;
    checkOutput("valid", 32'(E_valid), 32'(m_presenting));
    checkOutput("overrun", 32'(E_overrun), 32'(m_overrun));
    if (m_presenting || rs) begin
      checkOutput("code", 32'(E_code), 32'(m_code));
    end
  endtask

  initial begin
    logic [N-1:0] lines;
    logic         rdy;
    total_checks  = 0;
    passed_checks = 0;
    E_in      = '1;
    E_ready   = 1'b1;
    E_ovr_clr = 1'b0;
    rst       = 1'b1;

    // Lines high through reset release must never produce an event.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (4) applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

    // Single event on line 2, then two simultaneous events served 0 then 7.
    applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

    // Line 3 pulses twice while the consumer stalls, then the flag is cleared.
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    repeat (6) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

    // Line 3 rises again on the exact edge its handshake clears it.
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);

    // Reset while presenting drops everything.
    applyStimulus(8'h28, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(8'h28, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

    lines = '0;
    for (int c = 0; c < 3000; c++) begin
      lines = lines ^ N'($urandom & $urandom & $urandom);
      rdy   = (($urandom % 4) != 0);
      if ((c / 300) % 2 == 1) rdy = (($urandom % 4) == 0);
      applyStimulus(lines, rdy, (($urandom % 16) == 0), (($urandom % 400) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter N, default 8, number of event input lines; SHALL be a power of two, 2..16.
REQ-002 Parameter CW, default 3, code width; SHALL equal log2(N).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 E_in  input  N  event lines, synchronous to clk; a 0->1 transition on bit i is one event on line i.
REQ-006 E_ready  input  1  consumer accepts the presented code when high together with E_valid.
REQ-007 E_ovr_clr  input  1  synchronous clear of E_overrun.
REQ-008 E_code  output  CW  binary index of the presented event line.
REQ-009 E_valid  output  1  E_code holds a pending event.
REQ-010 E_overrun  output  1  sticky flag: an event was lost.

Function
REQ-011 Register prev SHALL hold E_in from the previous edge; rise = E_in & ~prev.
REQ-012 Pending vector pend[N-1:0] SHALL set bit i at the edge where rise[i]=1.
REQ-013 Handshake = E_valid & E_ready; at a handshake edge, pend[E_code] SHALL clear.
REQ-014 If rise[i] and the handshake clear of bit i occur at the same edge, pend[i] SHALL remain 1 (new event kept), E_overrun unchanged.
REQ-015 If rise[i]=1 while pend[i]=1 and bit i is not cleared at that edge, E_overrun SHALL set to 1.
REQ-016 E_overrun SHALL clear when E_ovr_clr=1 unless an overrun condition occurs at the same edge (set wins).
REQ-017 FSM states IDLE and PRESENT.
REQ-018 IDLE: if pend != 0, E_code <= lowest index i with pend[i]=1, E_valid <= 1, go PRESENT; else stay, E_valid=0.
REQ-019 PRESENT: E_code and E_valid SHALL hold stable until handshake; at handshake E_valid <= 0, go IDLE.
REQ-020 Throughput: at most one code per two cycles (one IDLE bubble after each handshake).
REQ-021 Latency: an event sampled at edge k with FSM in IDLE and no lower pending bit SHALL give E_valid=1 after edge k+1.
REQ-022 Priority: lowest index wins; a lower-index event arriving during PRESENT SHALL NOT alter the presented code.
REQ-023 Levels held high SHALL produce exactly one event; no event on 1->0.

Reset
REQ-024 On rst=1 at an edge: pend=0, FSM=IDLE, E_valid=0, E_code=0, E_overrun=0.
REQ-025 On rst, prev SHALL load all-ones so lines high through reset do not produce events.
REQ-026 Reset mid-PRESENT SHALL drop the presented code and all pending events without handshake.
REQ-027 rst SHALL take priority over every other input at the same edge.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, PRESENT=1) and default N/CW constants.
REQ-029 Sub-module lsb_prio_enc (N-bit vector -> CW-bit lowest-set index plus any-set flag, combinational) SHALL implement the priority selection.

Verification
REQ-030 E_in=0x04 from 0x00, E_ready=1 -> E_valid=1, E_code=2 after second edge; one handshake; pend=0.
REQ-031 E_in=0x81 same edge, E_ready=1 -> codes 0 then 7 on successive handshakes, one IDLE cycle between.
REQ-032 E_ready=0, line 3 pulses twice -> E_code=3 held, E_overrun=1; E_ovr_clr=1 -> E_overrun=0.
REQ-033 Line 3 rises on the handshake edge that clears bit 3 -> E_overrun stays 0, code 3 presented again.
REQ-034 E_in=0xFF held through rst release -> no E_valid ever; rst during PRESENT -> E_valid=0 next cycle, pend=0.
